// File: rtl/mux4_stream.sv
// 4:1 registered valid/ready stream multiplexer with fixed-select or round-robin
// channel choice; the output carries the source channel index.
module mux4_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [3:0]       v,
  output logic [3:0]       rdy,
  output logic [WIDTH-1:0] y,
  output logic [1:0]       y_sel,
  output logic             y_valid,
  input  logic             y_ready
);

  logic [1:0]       rr_ptr;
  logic [1:0]       grant_idx;
  logic             grant_vld;
  logic [1:0]       scan_idx;
  logic             load_en;
  logic             xfer;
  logic [WIDTH-1:0] data_p0;

  assign load_en = !y_valid || y_ready;

  // Reverse scan so the channel closest to rr_ptr is written last and wins.
  always_comb begin
    grant_idx = s;
    grant_vld = 1'b0;
    scan_idx  = rr_ptr;
    if (!mode) begin
      grant_vld = v[s];
    end else begin
      for (int k = 3; k >= 0; k--) begin
        scan_idx = rr_ptr + 2'(k);
        if (v[scan_idx]) begin
          grant_idx = scan_idx;
          grant_vld = 1'b1;
        end
      end
    end
  end

  // No channel is offered a transfer while reset is asserted.
  assign xfer = rst_n && load_en && grant_vld;
  assign rdy  = xfer ? (4'b0001 << grant_idx) : 4'b0000;

  // Only the granted channel's data reaches the register input.
  always_comb begin
    case (grant_idx)
      2'd0:    data_p0 = i0;
      2'd1:    data_p0 = i1;
      2'd2:    data_p0 = i2;
      default: data_p0 = i3;
    endcase
  end

  // ---- stage p0 -> output register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y       <= '0;
      y_sel   <= 2'd0;
      y_valid <= 1'b0;
      rr_ptr  <= 2'd0;
    end else if (xfer) begin
      y       <= data_p0;
      y_sel   <= grant_idx;
      y_valid <= 1'b1;
      rr_ptr  <= grant_idx + 2'd1;
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux4_stream.sv
// Bench for mux4_stream: vector table with per-cycle rdy/output expectations,
// plus a reference model and scoreboard checking every word delivered downstream.
module tb_mux4_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic [1:0] s;
  logic [7:0] i0, i1, i2, i3;
  logic [3:0] v;
  logic [3:0] rdy;
  logic [7:0] y;
  logic [1:0] y_sel;
  logic       y_valid;
  logic       y_ready;

  int n_chk  = 0;
  int n_fail = 0;

  mux4_stream #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .s(s),
    .i0(i0), .i1(i1), .i2(i2), .i3(i3), .v(v), .rdy(rdy),
    .y(y), .y_sel(y_sel), .y_valid(y_valid), .y_ready(y_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] chan_data(input int k);
    case (k)
      0:       return i0;
      1:       return i1;
      2:       return i2;
      default: return i3;
    endcase
  endfunction

  // Reference model and scoreboard, evaluated on the falling edge.
  logic [9:0] sb[$];
  logic       m_yv  = 1'b0;
  logic [1:0] m_ptr = 2'd0;

  always @(negedge clk) begin
    int         gk;
    logic       load;
    logic [3:0] exp_r;
    logic [9:0] w;
    if (!rst_n) begin
      chk("rdy_in_reset", {28'd0, rdy}, 32'd0);
      m_yv  = 1'b0;
      m_ptr = 2'd0;
      sb.delete();
    end else begin
      chk("y_valid_model", {31'd0, y_valid}, {31'd0, m_yv});
      if (m_yv && y_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          w = sb.pop_front();
          chk("sb_y", {24'd0, y}, {24'd0, w[9:2]});
          chk("sb_y_sel", {30'd0, y_sel}, {30'd0, w[1:0]});
        end
      end
      load = !m_yv || y_ready;
      gk = -1;
      if (!mode) begin
        if (v[s]) gk = int'(s);
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (gk < 0 && v[(int'(m_ptr) + k) % 4]) gk = (int'(m_ptr) + k) % 4;
        end
      end
      exp_r = (load && gk >= 0) ? (4'b0001 << gk) : 4'b0000;
      chk("rdy_model", {28'd0, rdy}, {28'd0, exp_r});
      if (exp_r != 4'b0000) begin
        sb.push_back({chan_data(gk), 2'(gk)});
        m_ptr = 2'(gk + 1);
        m_yv  = 1'b1;
      end else if (y_ready) begin
        m_yv = 1'b0;
      end
    end
  end

  typedef struct {
    logic       rst_n;
    logic       mode;
    logic [1:0] s;
    logic [3:0] v;
    logic [7:0] d0, d1, d2, d3;
    logic       yr;
    logic [3:0] er;
    logic       cy;
    logic [7:0] ey;
    logic [1:0] es;
    logic       ev;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic m, input logic [1:0] sel,
                              input logic [3:0] vv, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d, input logic yr,
                              input logic [3:0] er, input logic cy, input logic [7:0] ey,
                              input logic [1:0] es, input logic ev);
    vec_t t;
    t.rst_n = r; t.mode = m; t.s = sel; t.v = vv;
    t.d0 = a; t.d1 = b; t.d2 = c; t.d3 = d; t.yr = yr; t.er = er;
    t.cy = cy; t.ey = ey; t.es = es; t.ev = ev;
    return t;
  endfunction

  task automatic drive(input logic r, input logic m, input logic [1:0] sel, input logic [3:0] vv,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] d, input logic yr);
    rst_n = r; mode = m; s = sel; v = vv; i0 = a; i1 = b; i2 = c; i3 = d; y_ready = yr;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] ey, input logic [1:0] es, input logic ev);
    chk({tag, "_y"}, {24'd0, y}, {24'd0, ey});
    chk({tag, "_y_sel"}, {30'd0, y_sel}, {30'd0, es});
    chk({tag, "_y_valid"}, {31'd0, y_valid}, {31'd0, ev});
  endtask

  vec_t tbl[$];

  initial begin
    // reset with all valids high
    tbl.push_back(mk(0, 1, 0, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0000, 0, 0, 0, 0));
    // round-robin over four busy channels, no bubbles
    tbl.push_back(mk(1, 1, 0, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0001, 1, 8'h00, 0, 0));
    tbl.push_back(mk(1, 1, 0, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0010, 1, 8'h10, 0, 1));
    tbl.push_back(mk(1, 1, 0, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0100, 1, 8'h11, 1, 1));
    tbl.push_back(mk(1, 1, 0, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b1000, 1, 8'h12, 2, 1));
    tbl.push_back(mk(1, 1, 0, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0001, 1, 8'h13, 3, 1));
    tbl.push_back(mk(1, 1, 0, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0010, 1, 8'h10, 0, 1));
    tbl.push_back(mk(1, 1, 0, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0100, 1, 8'h11, 1, 1));
    tbl.push_back(mk(1, 1, 0, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b1000, 1, 8'h12, 2, 1));
    // fixed select s=2, then s=1 with v[1]=0
    tbl.push_back(mk(1, 0, 2, 4'b0101, 8'h10, 8'h11, 8'hA5, 8'h13, 1, 4'b0100, 1, 8'h13, 3, 1));
    tbl.push_back(mk(1, 0, 1, 4'b0101, 8'h10, 8'h11, 8'hA5, 8'h13, 1, 4'b0000, 1, 8'hA5, 2, 1));
    tbl.push_back(mk(1, 0, 1, 4'b0000, 8'h10, 8'h11, 8'hA5, 8'h13, 1, 4'b0000, 1, 8'hA5, 2, 0));
    // sparse round-robin from rr_ptr=3
    tbl.push_back(mk(1, 1, 0, 4'b0010, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0010, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 4'b0011, 8'h10, 8'h11, 8'h12, 8'h13, 1, 4'b0001, 1, 8'h11, 1, 1));
    // backpressure: hold 3C for three stalled cycles, then drain and load i3 together
    tbl.push_back(mk(1, 0, 0, 4'b0001, 8'h3C, 8'h11, 8'h12, 8'hC3, 1, 4'b0001, 1, 8'h10, 0, 1));
    tbl.push_back(mk(1, 0, 3, 4'b1000, 8'h3C, 8'h11, 8'h12, 8'hC3, 0, 4'b0000, 1, 8'h3C, 0, 1));
    tbl.push_back(mk(1, 0, 3, 4'b1000, 8'h3C, 8'h11, 8'h12, 8'hC3, 0, 4'b0000, 1, 8'h3C, 0, 1));
    tbl.push_back(mk(1, 0, 3, 4'b1000, 8'h3C, 8'h11, 8'h12, 8'hC3, 0, 4'b0000, 1, 8'h3C, 0, 1));
    tbl.push_back(mk(1, 0, 3, 4'b1000, 8'h3C, 8'h11, 8'h12, 8'hC3, 1, 4'b1000, 1, 8'h3C, 0, 1));
    tbl.push_back(mk(1, 0, 3, 4'b0000, 8'h3C, 8'h11, 8'h12, 8'hC3, 1, 4'b0000, 1, 8'hC3, 3, 1));
    tbl.push_back(mk(1, 0, 3, 4'b0000, 8'h3C, 8'h11, 8'h12, 8'hC3, 1, 4'b0000, 1, 8'hC3, 3, 0));

    drive(0, 1, 0, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1);
    for (int n = 0; n < tbl.size(); n++) begin
      drive(tbl[n].rst_n, tbl[n].mode, tbl[n].s, tbl[n].v,
            tbl[n].d0, tbl[n].d1, tbl[n].d2, tbl[n].d3, tbl[n].yr);
      @(negedge clk);
      chk($sformatf("vec%0d_rdy", n), {28'd0, rdy}, {28'd0, tbl[n].er});
      if (tbl[n].cy) chk_out($sformatf("vec%0d", n), tbl[n].ey, tbl[n].es, tbl[n].ev);
      @(posedge clk);
      #1;
    end

    // Reset while a word is stalled with rr_ptr=2; afterwards round-robin restarts at 0.
    drive(1, 0, 1, 4'b0010, 8'h77, 8'h5A, 8'h66, 8'h88, 1);
    @(negedge clk);
    chk("mid_load_rdy", {28'd0, rdy}, 32'h2);
    @(posedge clk); #1;
    drive(1, 0, 1, 4'b0000, 8'h77, 8'h5A, 8'h66, 8'h88, 0);
    @(negedge clk);
    chk_out("mid_stall", 8'h5A, 1, 1);
    @(posedge clk); #1;
    drive(0, 1, 0, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 0);
    @(negedge clk);
    chk("mid_rst_rdy", {28'd0, rdy}, 32'h0);
    @(posedge clk); #1;
    drive(1, 1, 0, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13, 1);
    @(negedge clk);
    chk_out("after_rst", 8'h00, 0, 0);
    chk("after_rst_rdy", {28'd0, rdy}, 32'h1);
    @(posedge clk); #1;
    drive(1, 1, 0, 4'b0000, 8'h10, 8'h11, 8'h12, 8'h13, 1);
    @(negedge clk);
    chk_out("after_rst_load", 8'h10, 0, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4_stream.md
Name: mux4_stream

Overview:
4:1 registered stream multiplexer. It is the gathering counterpart of the team's 1:4 demultiplexer: it merges four independent valid/ready input channels onto one output channel. Channel choice is either the external 2-bit select `s` (fixed mode) or a fair round-robin arbiter. The output carries the source channel index so a downstream demultiplexer can re-route the data.

Parameters:
WIDTH, 8, data width of every input channel and of the output.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
mode  input  1  0 = fixed select by s; 1 = round-robin
s  input  2  channel select, used when mode=0
i0  input  WIDTH  channel 0 data
i1  input  WIDTH  channel 1 data
i2  input  WIDTH  channel 2 data
i3  input  WIDTH  channel 3 data
v  input  4  per-channel valid, bit k belongs to ik
rdy  output  4  per-channel ready (combinational), bit k belongs to ik
y  output  WIDTH  registered output data
y_sel  output  2  registered index of the channel that produced y
y_valid  output  1  output valid
y_ready  input  1  downstream ready

Behaviour:
- Single clock domain. Reset is synchronous and active-low, sampled on the rising edge of clk. While rst_n=0 at an edge: y=0, y_sel=0, y_valid=0, rr_ptr=0.
- Reset has priority over everything, including mid-transfer. A held word is discarded and no rdy is asserted during that cycle.
- Internal state:
  - output register: y, y_sel, y_valid;
  - 2-bit rr_ptr, the highest-priority channel for round-robin.
- Load enable: load_en = !y_valid || y_ready. The output stage is a one-deep pipeline register. Full throughput is one word per cycle; latency is one cycle from input accept to y_valid.
- Grant, combinational, at most one channel:
  - mode=0: grant channel s if v[s]=1, otherwise no grant. Valids on other channels are ignored.
  - mode=1: grant the first k with v[k]=1, scanning rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3 (mod 4). No grant if v=0.
- rdy[k] = load_en && grant[k]. rdy is one-hot or zero. rdy depending on v is permitted; upstream must not make v depend on rdy.
- Transfer on channel k happens at an edge where v[k] && rdy[k]. Then:
  - y <= ik, y_sel <= k, y_valid <= 1;
  - rr_ptr <= (k+1) mod 4. rr_ptr updates in both modes.
- If y_valid && y_ready and there is no new transfer: y_valid <= 0. y and y_sel hold their last values.
- Stall: while y_valid=1 and y_ready=0, y, y_sel and y_valid stay stable and rdy=0.
- Simultaneous drain and load (y_valid=1, y_ready=1, new transfer) replaces the register in the same edge with no bubble.
- A mode or s change takes effect combinationally for the next grant. It never alters a word already held in the output register.
- rr_ptr wraps 3 -> 0. With all four valids held high in mode=1, the grant order is 0,1,2,3,0,...
- X/Z on an unselected channel's data must not propagate to y.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with v=4'b1111 and y_ready=1 -> rdy=0, y=0, y_sel=0, y_valid=0. After release, the first accept is on channel 0 in mode=1.
2. Fixed mode: mode=0, s=2, i2=8'hA5, v=4'b0101, y_ready=1 -> rdy=4'b0100. Next cycle y=8'hA5, y_sel=2, y_valid=1. Then set s=1 with v[1]=0 -> rdy=0 and y_valid drops after one cycle.
3. Round-robin fairness: mode=1, v=4'b1111, i0..i3=8'h10,8'h11,8'h12,8'h13, y_ready=1 for 8 cycles -> y_sel sequence 0,1,2,3,0,1,2,3 and y sequence 10,11,12,13,10,11,12,13, with no bubbles.
4. Backpressure: y_valid=1 with y=8'h3C; hold y_ready=0 for 3 cycles while v=4'b1000 -> y=8'h3C stable and rdy=0 throughout. On the y_ready=1 edge, load i3 in the same cycle with no idle cycle.
5. Sparse round-robin: rr_ptr=3, v=4'b0010 -> grant channel 1 and rr_ptr becomes 2. Next, v=4'b0011 -> grant channel 0, since the scan runs 2,3,0.
6. Reset mid-operation: y_valid=1, y_ready=0, rr_ptr=2; pulse rst_n=0 for one edge -> y_valid=0, y=0, rr_ptr=0. The next mode=1 accept with v=4'b1111 is channel 0.
